// File: rtl/burst_mem_bridge.sv
// Splits 4-beat x 64-bit line bursts into single-word req/gnt memory accesses.
// Optional macro BURST_MEM_BRIDGE_RDATA_REG_EN registers the read-return path.
module burst_mem_bridge #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bmem_addr,
    input  logic        bmem_read,
    input  logic        bmem_write,
    input  logic [63:0] bmem_wdata,
    output logic        bmem_ready,
    output logic        bmem_rvalid,
    output logic [63:0] bmem_rdata,
    output logic        sram_req,
    output logic        sram_we,
    output logic [31:0] sram_addr,
    output logic [63:0] sram_wdata,
    input  logic        sram_gnt,
    input  logic        sram_rvalid,
    input  logic [63:0] sram_rdata
);
    typedef enum logic [1:0] {IDLE, RD_ISSUE, WR_COLLECT, WR_ISSUE} state_t;

    localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

    state_t       state, state_nxt;
    logic [31:0]  base;
    logic [2:0]   iss, ret, outstanding;
    logic [1:0]   idx;
    logic [255:0] wbuf;
    logic         fwd, rd_grant;
    logic         unused_addr_lsb;

    assign unused_addr_lsb = ^bmem_addr[4:0];

    // Returns with nothing in flight are strays (e.g. from a burst killed by reset).
    assign fwd      = sram_rvalid && (outstanding != 3'd0);
    assign rd_grant = sram_req && sram_gnt && !sram_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        bmem_ready = 1'b0;
        sram_req   = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        case (state)
            IDLE: begin
                bmem_ready = 1'b1;
                if (bmem_write)     state_nxt = WR_COLLECT;
                else if (bmem_read) state_nxt = RD_ISSUE;
            end
            RD_ISSUE: begin
                if (iss < 3'd4 && outstanding < MAX_OUT) begin
                    sram_req  = 1'b1;
                    sram_addr = base + {26'd0, iss, 3'b000};
                end
`ifdef BURST_MEM_BRIDGE_RDATA_REG_EN
                // hold one extra cycle so the registered last beat leaves first
                if (ret == 3'd4) state_nxt = IDLE;
`else
                if (fwd && ret == 3'd3) state_nxt = IDLE;
`endif
            end
            WR_COLLECT: begin
                if (bmem_write && idx == 2'd3) state_nxt = WR_ISSUE;
            end
            WR_ISSUE: begin
                sram_req   = 1'b1;
                sram_we    = 1'b1;
                sram_addr  = base + {26'd0, iss, 3'b000};
                sram_wdata = wbuf[{iss[1:0], 6'b0} +: 64];
                if (sram_gnt && iss == 3'd3) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base        <= '0;
            iss         <= '0;
            ret         <= '0;
            idx         <= '0;
            wbuf        <= '0;
            outstanding <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bmem_write) begin
                        base        <= {bmem_addr[31:5], 5'b0};
                        wbuf[63:0]  <= bmem_wdata;
                        idx         <= 2'd1;
                        iss         <= '0;
                    end else if (bmem_read) begin
                        base <= {bmem_addr[31:5], 5'b0};
                        iss  <= '0;
                        ret  <= '0;
                    end
                end
                RD_ISSUE: begin
                    if (rd_grant) iss <= iss + 3'd1;
                    if (fwd)      ret <= ret + 3'd1;
                end
                WR_COLLECT: begin
                    if (bmem_write) begin
                        wbuf[{idx, 6'b0} +: 64] <= bmem_wdata;
                        idx                     <= idx + 2'd1;
                    end
                end
                WR_ISSUE: begin
                    if (sram_gnt) iss <= iss + 3'd1;
                end
                default: ;
            endcase
            // simultaneous grant and return cancel out
            case ({rd_grant, fwd})
                2'b10:   outstanding <= outstanding + 3'd1;
                2'b01:   outstanding <= outstanding - 3'd1;
                default: ;
            endcase
        end
    end

`ifdef BURST_MEM_BRIDGE_RDATA_REG_EN
    logic        rvalid_q;
    logic [63:0] rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= fwd;
            rdata_q  <= fwd ? sram_rdata : '0;
        end
    end

    assign bmem_rvalid = rvalid_q;
    assign bmem_rdata  = rdata_q;
`else
    assign bmem_rvalid = fwd;
    assign bmem_rdata  = fwd ? sram_rdata : '0;
`endif

endmodule

// File: tb/tb_burst_mem_bridge.sv
// Randomized directed bench for burst_mem_bridge with a behavioural word memory.
module tb_burst_mem_bridge;
    localparam int MAXO = 2;
`ifdef BURST_MEM_BRIDGE_RDATA_REG_EN
    localparam int RLAT = 1;
`else
    localparam int RLAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bmem_addr;
    logic        bmem_read, bmem_write;
    logic [63:0] bmem_wdata;
    logic        bmem_ready, bmem_rvalid;
    logic [63:0] bmem_rdata;
    logic        sram_req, sram_we;
    logic [31:0] sram_addr;
    logic [63:0] sram_wdata;
    logic        sram_gnt, sram_rvalid;
    logic [63:0] sram_rdata;

    burst_mem_bridge #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_rvalid(bmem_rvalid),
        .bmem_rdata(bmem_rdata), .sram_req(sram_req), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_gnt(sram_gnt),
        .sram_rvalid(sram_rvalid), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [63:0] data; } pend_t;

    int total = 0, bad = 0;
    int cyc = 0, lat = 1, model_out = 0, viol = 0, rv_err = 0;
    int rdy_rise = 0, wr_total = 0, rd_total = 0;
    logic gnt_rand = 1'b0, rdy_prev = 1'b0;
    logic exp_v_q = 1'b0;
    logic [63:0] exp_d_q = '0;
    pend_t       pend[$];
    logic [63:0] got[$], wr_data[$];
    logic [31:0] rd_addrs[$], wr_addrs[$];
    int          rd_cyc[$], wr_cyc[$];
    logic [63:0] mem[logic [31:0]];
    logic [63:0] shadow[logic [31:0]];

    function automatic logic [63:0] dflt(input logic [31:0] a);
        return {a, ~a};
    endfunction

    function automatic logic [63:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return dflt(a);
    endfunction

    function automatic logic [63:0] exp_word(input logic [31:0] a);
        if (shadow.exists(a)) return shadow[a];
        return dflt(a);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory model and monitor: drive at negedge, observe 1 ns later.
    always @(negedge clk) begin
        logic        rv_now, rv_cmp, grant;
        logic [63:0] rd_now, rd_cmp;
        int          out0;
        cyc++;
        sram_rvalid = 1'b0;
        sram_rdata  = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            sram_rvalid = 1'b1;
            sram_rdata  = pend[0].data;
            pend.delete(0);
        end
        sram_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (!rst) begin
            model_out = 0;
            exp_v_q   = 1'b0;
            exp_d_q   = '0;
        end
        out0   = model_out;
        rv_now = rst && sram_rvalid && out0 > 0;
        rd_now = rv_now ? sram_rdata : '0;
        rv_cmp = (RLAT != 0) ? exp_v_q : rv_now;
        rd_cmp = (RLAT != 0) ? exp_d_q : rd_now;
        if (bmem_rvalid !== rv_cmp || (rv_cmp && bmem_rdata !== rd_cmp)) rv_err++;
        exp_v_q = rv_now;
        exp_d_q = rd_now;
        if (bmem_rvalid) got.push_back(bmem_rdata);
        if (sram_req && !sram_we && out0 >= MAXO) viol++;
        if (bmem_ready && !rdy_prev) rdy_rise = cyc;
        rdy_prev = bmem_ready;
        grant = rst && sram_req && sram_gnt;
        if (grant && sram_we) begin
            wr_addrs.push_back(sram_addr);
            wr_data.push_back(sram_wdata);
            wr_cyc.push_back(cyc);
            mem[sram_addr] = sram_wdata;
            wr_total++;
        end else if (grant) begin
            rd_addrs.push_back(sram_addr);
            rd_cyc.push_back(cyc);
            pend.push_back('{due: cyc + lat, data: mem_rd(sram_addr)});
            rd_total++;
        end
        model_out = out0 + ((grant && !sram_we) ? 1 : 0) - (rv_now ? 1 : 0);
    end

    // Starts and ends aligned to a negedge.
    task automatic do_read(input logic [31:0] a, input int hold, input bit timing, output int acc);
        int k;
        logic [31:0] base;
        base = {a[31:5], 5'b0};
        got.delete(); rd_addrs.delete(); rd_cyc.delete();
        bmem_addr = a;
        bmem_read = 1'b1;
        k = 0;
        #2;
        while (!bmem_ready && k < 300) begin @(negedge clk); #2; k++; end
        acc = cyc;
        chk("rd_accept_tmo", 64'(k < 300), 64'd1);
        @(negedge clk);
        repeat (hold) @(negedge clk);
        bmem_read = 1'b0;
        k = 0;
        #2;
        while ((got.size() < 4 || !bmem_ready) && k < 300) begin @(negedge clk); #2; k++; end
        chk("rd_done_tmo", 64'(k < 300), 64'd1);
        repeat (3) @(negedge clk);
        chk("rd_word_count", 64'(rd_addrs.size()), 64'd4);
        chk("rd_beat_count", 64'(got.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < rd_addrs.size()) chk("rd_addr", 64'(rd_addrs[i]), 64'(base + 32'(8 * i)));
            if (i < got.size())      chk("rd_data", got[i], exp_word(base + 32'(8 * i)));
        end
        if (timing && rd_cyc.size() == 4) begin
            chk("rd_first_req", 64'(rd_cyc[0] - acc), 64'd1);
            chk("rd_last_req", 64'(rd_cyc[3] - acc), 64'd4);
            chk("rd_ready_rise", 64'(rdy_rise - acc), 64'(6 + RLAT));
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0][63:0] d, input int gap,
                            input bit rd_too, input bit timing, output int wacc);
        int k;
        logic [31:0] base;
        base = {a[31:5], 5'b0};
        wr_addrs.delete(); wr_data.delete(); wr_cyc.delete();
        bmem_addr  = a;
        bmem_write = 1'b1;
        bmem_wdata = d[0];
        if (rd_too) bmem_read = 1'b1;
        k = 0;
        #2;
        while (!bmem_ready && k < 300) begin @(negedge clk); #2; k++; end
        wacc = cyc;
        chk("wr_accept_tmo", 64'(k < 300), 64'd1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            if (i == 2) repeat (gap) begin bmem_write = 1'b0; @(negedge clk); end
            bmem_write = 1'b1;
            bmem_wdata = d[i];
        end
        @(negedge clk);
        bmem_write = 1'b0;
        k = 0;
        while (wr_addrs.size() < 4 && k < 300) begin @(negedge clk); k++; end
        chk("wr_done_tmo", 64'(k < 300), 64'd1);
        for (int i = 0; i < 4; i++) begin
            shadow[base + 32'(8 * i)] = d[i];
            if (i < wr_addrs.size()) begin
                chk("wr_addr", 64'(wr_addrs[i]), 64'(base + 32'(8 * i)));
                chk("wr_data", wr_data[i], d[i]);
            end
        end
        if (timing && wr_cyc.size() == 4) chk("wr_first_req", 64'(wr_cyc[0] - wacc), 64'd4);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0][63:0] d;
        logic [31:0] a;
        int acc, wacc, nwr, nrd, k;
        nwr = 0; nrd = 0;
        rst = 1'b0; bmem_addr = '0; bmem_read = 1'b0; bmem_write = 1'b0; bmem_wdata = '0;
        repeat (3) @(negedge clk);
        bmem_read = 1'b1;
        #2;
        chk("rst_bmem_ready", 64'(bmem_ready), 64'd1);
        chk("rst_bmem_rvalid", 64'(bmem_rvalid), 64'd0);
        chk("rst_bmem_rdata", bmem_rdata, 64'd0);
        chk("rst_sram_req", 64'(sram_req), 64'd0);
        chk("rst_sram_we", 64'(sram_we), 64'd0);
        chk("rst_sram_addr", 64'(sram_addr), 64'd0);
        chk("rst_sram_wdata", sram_wdata, 64'd0);
        @(negedge clk);
        bmem_read = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // ideal memory, read held high past acceptance
        lat = 1; gnt_rand = 1'b0;
        do_read(32'h0000_1234, 3, 1'b1, acc); nrd++;
        chk("ideal_rv_err", 64'(rv_err), 64'd0);

        // slow memory exercises the outstanding cap
        lat = 5;
        do_read(32'h0000_5008, 0, 1'b0, acc); nrd++;
        chk("maxout_viol", 64'(viol), 64'd0);

        // write then read, both requested together; write wins
        lat = 1; gnt_rand = 1'b0;
        d = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        do_write(32'h0000_2000, d, 0, 1'b1, 1'b1, wacc); nwr++;
        do_read(32'h0000_2000, 0, 1'b0, acc); nrd++;
        chk("wr_then_rd_accept", 64'(acc - wacc), 64'd8);
        for (int i = 0; i < 4; i++)
            if (i < got.size()) chk("wr_then_rd_data", got[i], 64'(8'hA0 + i));

        // write with a 2-cycle hole and toggling grant
        gnt_rand = 1'b1;
        d = {64'h3333_0003, 64'h2222_0002, 64'h1111_0001, 64'h0000_0000};
        do_write(32'h0000_4010, d, 2, 1'b0, 1'b0, wacc); nwr++;
        do_read(32'h0000_4000, 1, 1'b0, acc); nrd++;
        chk("gap_rv_err", 64'(rv_err), 64'd0);

        // reset after two grants, late returns land after release
        lat = 5; gnt_rand = 1'b0;
        got.delete(); rd_addrs.delete();
        bmem_addr = 32'h0000_3000; bmem_read = 1'b1;
        @(negedge clk);
        bmem_read = 1'b0;
        k = 0;
        while (rd_addrs.size() < 2 && k < 100) begin @(negedge clk); k++; end
        chk("rstmid_grant_tmo", 64'(k < 100), 64'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        #2;
        chk("rstmid_no_beats", 64'(got.size()), 64'd0);
        chk("rstmid_ready", 64'(bmem_ready), 64'd1);
        chk("rstmid_rv_err", 64'(rv_err), 64'd0);
        @(negedge clk);
        lat = 1;
        do_read(32'h0000_3000, 0, 1'b1, acc); nrd++;

        // random bursts, latencies and grant patterns
        for (int it = 0; it < 8; it++) begin
            a = $urandom;
            lat = $urandom_range(1, 5);
            gnt_rand = 1'b1;
            for (int j = 0; j < 4; j++) d[j] = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, d, $urandom_range(0, 2), 1'b0, 1'b0, wacc); nwr++;
            end
            do_read(a, $urandom_range(0, 3), 1'b0, acc); nrd++;
        end

        repeat (10) @(negedge clk);
        chk("final_rv_err", 64'(rv_err), 64'd0);
        chk("final_maxout_viol", 64'(viol), 64'd0);
        chk("final_wr_total", 64'(wr_total), 64'(4 * nwr));
        chk("final_rd_total", 64'(rd_total), 64'(4 * nrd + 2));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
